// File: rtl/spi_slave_receiver.sv
// SPI mode-0 receive endpoint: synchronizes ss_n/sclk/mosi into the clock domain, shifts
// words in MSB-first, and hands them off through a valid/ready holding register.
module spi_slave_receiver #(
    parameter int unsigned WIDTH       = 8,  // must be >= 2
    parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ss_n,
    input  logic             sclk,
    input  logic             mosi,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             frame_error,
    output logic             busy
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StReceive
    } state_e;

    // Input synchronizers and edge detection
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_d_q;
    logic                   ss_d_q;
    logic                   ss_n_s;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   rise;
    logic                   ss_fall;

    // Chains reset to 0 so a frame already in flight at reset release never yields ss_fall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ss_sync_q   <= '0;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_d_q    <= 1'b0;
            ss_d_q      <= 1'b0;
        end else begin
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_d_q    <= sclk_s;
            ss_d_q      <= ss_n_s;
        end
    end

    assign ss_n_s  = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync_q[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_d_q;
    assign ss_fall = ~ss_n_s & ss_d_q;

    // FSM: state register
    state_e state_q;
    state_e state_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d = StReceive;
                end
            end
            StReceive: begin
                if (ss_n_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: decoded actions
    logic [CntW-1:0] cnt_q;
    logic            start;
    logic            shift_en;
    logic            word_done;
    logic            abort;
    logic            partial;

    // Deassertion takes priority over a coincident sclk rise.
    always_comb begin
        busy      = (state_q == StReceive);
        start     = (state_q == StIdle) & ss_fall;
        shift_en  = (state_q == StReceive) & ~ss_n_s & rise;
        word_done = shift_en & (cnt_q == CntLast);
        abort     = (state_q == StReceive) & ss_n_s;
        partial   = abort & (cnt_q != '0);
    end

    // Datapath
    logic [WIDTH-2:0] shift_q;
    logic [WIDTH-2:0] shift_d;
    logic [WIDTH-1:0] shift_nx;
    logic [CntW-1:0]  cnt_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             valid_q;
    logic             valid_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             frame_error_q;
    logic             frame_error_d;

    always_comb begin
        shift_nx      = {shift_q, mosi_s};
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        data_d        = data_q;
        valid_d       = valid_q;
        overrun_d     = 1'b0;
        frame_error_d = partial;

        if (start || abort) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (shift_en) begin
            shift_d = shift_nx[WIDTH-2:0];
            cnt_d   = word_done ? '0 : cnt_q + 1'b1;
        end

        // A new word always wins; it only counts as overrun if the old one is not taken now.
        if (word_done) begin
            data_d    = shift_nx;
            valid_d   = 1'b1;
            overrun_d = valid_q & ~ready;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            shift_q       <= '0;
            cnt_q         <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign overrun     = overrun_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Directed bench for spi_slave_receiver: stimulus pushes expected words into a queue, a
// monitor pops and compares whenever a word is presented.
module tb_spi_slave_receiver;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ss_n  = 1'b1;
    logic       sclk  = 1'b0;
    logic       mosi  = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       overrun;
    logic       frame_error;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];

    int   fe_count       = 0;
    int   ovr_count      = 0;
    int   valid_len      = 0;
    int   last_valid_len = 0;
    int   evt_cyc        = 0;
    int   prev_evt_cyc   = 0;
    logic valid_prev     = 1'b0;
    logic ovr_prev       = 1'b0;
    logic fe_prev        = 1'b0;

    spi_slave_receiver #(
        .WIDTH      (8),
        .SYNC_STAGES(2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ss_n       (ss_n),
        .sclk       (sclk),
        .mosi       (mosi),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .overrun    (overrun),
        .frame_error(frame_error),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives change 1 time unit after the falling edge, well clear of the rising edge.
    task automatic clk_wait(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic ss_begin();
        ss_n = 1'b0;
        clk_wait(6);
    endtask

    task automatic ss_end();
        clk_wait(4);
        ss_n = 1'b1;
        clk_wait(10);
    endtask

    // sclk = clock/8, MSB first, mosi changes on the falling sclk edge.
    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            clk_wait(4);
            sclk = 1'b1;
            clk_wait(4);
            sclk = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] d, input logic o);
        exp_t e;
        e.data = d;
        e.ovr  = o;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " data"}, data, 0);
        check({tag, " valid"}, valid, 0);
        check({tag, " overrun"}, overrun, 0);
        check({tag, " frame_error"}, frame_error, 0);
        check({tag, " busy"}, busy, 0);
    endtask

    // Monitor: samples on the falling edge; a word is presented when valid rises or on overrun.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (!reset) begin
            valid_prev = 1'b0;
            ovr_prev   = 1'b0;
            fe_prev    = 1'b0;
            valid_len  = 0;
        end else begin
            if (frame_error) begin
                fe_count++;
                check("frame_error pulse width", fe_prev, 0);
                check("frame_error with busy low", busy, 0);
            end
            if (overrun) begin
                ovr_count++;
                check("overrun pulse width", ovr_prev, 0);
            end
            if ((valid && !valid_prev) || overrun) begin
                prev_evt_cyc = evt_cyc;
                evt_cyc      = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected word: got %0h, expected none", data);
                end else begin
                    e = exp_q.pop_front();
                    check("word data", data, e.data);
                    check("word overrun flag", overrun, e.ovr);
                    check("word valid", valid, 1);
                end
            end
            if (valid) begin
                valid_len++;
            end else if (valid_prev) begin
                last_valid_len = valid_len;
                valid_len      = 0;
            end
            valid_prev = valid;
            ovr_prev   = overrun;
            fe_prev    = frame_error;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe0;
        int ovr0;

        // Reset state
        clk_wait(4);
        check_reset_outputs("reset");
        reset = 1'b1;
        clk_wait(10);

        // Single word
        fe0 = fe_count;
        push(8'hA5, 1'b0);
        ss_begin();
        check("busy in frame", busy, 1);
        send_bits(32'hA5, 8);
        ss_end();
        check("busy after frame", busy, 0);
        check("single valid width", last_valid_len, 1);
        check("single no frame_error", fe_count, fe0);

        // Back-to-back words in one frame
        fe0  = fe_count;
        ovr0 = ovr_count;
        push(8'h3C, 1'b0);
        push(8'hC3, 1'b0);
        ss_begin();
        send_bits(32'h3CC3, 16);
        ss_end();
        check("back-to-back spacing", evt_cyc - prev_evt_cyc, 64);
        check("back-to-back no frame_error", fe_count, fe0);
        check("back-to-back no overrun", ovr_count, ovr0);

        // Overrun with ready held low
        ready = 1'b0;
        ovr0  = ovr_count;
        push(8'h11, 1'b0);
        push(8'h22, 1'b1);
        ss_begin();
        send_bits(32'h1122, 16);
        ss_end();
        check("overrun data", data, 8'h22);
        check("overrun valid held", valid, 1);
        check("overrun pulse count", ovr_count, ovr0 + 1);
        ready = 1'b1;
        clk_wait(1);
        ready = 1'b0;
        check("valid cleared by ready", valid, 0);
        ready = 1'b1;
        clk_wait(2);

        // Partial frame, then a good frame
        fe0 = fe_count;
        ss_begin();
        send_bits(32'h16, 5);
        ss_end();
        check("partial frame_error count", fe_count, fe0 + 1);
        push(8'h5A, 1'b0);
        ss_begin();
        send_bits(32'h5A, 8);
        ss_end();
        check("after partial data", data, 8'h5A);

        // Reset mid-frame, released while ss_n is still low
        fe0 = fe_count;
        ss_begin();
        send_bits(32'h5, 3);
        reset = 1'b0;
        clk_wait(3);
        check_reset_outputs("mid-frame reset");
        reset = 1'b1;
        send_bits(32'h0A, 5);
        ss_end();
        check("interrupted frame no frame_error", fe_count, fe0);
        check("interrupted frame no valid", valid, 0);
        push(8'h96, 1'b0);
        ss_begin();
        send_bits(32'h96, 8);
        ss_end();
        check("post-reset data", data, 8'h96);

        // ss_n deassert coincides with the 8th sclk rise
        fe0 = fe_count;
        ss_begin();
        send_bits(32'h55, 7);
        mosi = 1'b1;
        clk_wait(4);
        sclk = 1'b1;
        ss_n = 1'b1;
        clk_wait(4);
        sclk = 1'b0;
        clk_wait(10);
        check("collision frame_error count", fe_count, fe0 + 1);
        check("collision data unchanged", data, 8'h96);

        check("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
